// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the message padder state encoding.
// The compression core imports this package as well.
package sha256_pkg;

    localparam int SHA256_BLOCK_BITS  = 512;
    localparam int SHA256_BLOCK_BYTES = 64;
    localparam int SHA256_LEN_BYTES   = 8;
    localparam int SHA256_LEN_OFFSET  = 56;

    localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SEND  = 2'd1,
        EXTRA = 2'd2
    } padder_state_t;

endpackage

// File: rtl/sha256_pad_builder.sv
// Combinational block former: merges buffered message bytes with the 0x80
// marker, zero fill and the big-endian bit length.
// i_p is the number of message bytes held in i_buf (1..64). With i_extra set
// the buffer is ignored and the trailing padding-only block is produced;
// its byte 0 carries the marker only when the previous block was full.
module sha256_pad_builder
    import sha256_pkg::*;
(
    input  logic [SHA256_BLOCK_BITS-1:0] i_buf,
    input  logic [6:0]                   i_p,
    input  logic [63:0]                  i_len,
    input  logic                         i_extra,
    output logic [SHA256_BLOCK_BITS-1:0] o_block
);

    genvar gi;
    generate
        for (gi = 0; gi < SHA256_BLOCK_BYTES; gi++) begin : g_byte
            logic [7:0] w_byte;

            if (gi >= SHA256_LEN_OFFSET) begin : g_len
                // Tail bytes: length field when it fits, otherwise message/marker/zero
                always_comb begin
                    w_byte = 8'h00;
                    if (i_extra || (i_p <= 7'(SHA256_LEN_OFFSET - 1)))
                        w_byte = i_len[(SHA256_BLOCK_BYTES - 1 - gi) * 8 +: 8];
                    else if (7'(gi) < i_p)
                        w_byte = i_buf[SHA256_BLOCK_BITS - 1 - 8 * gi -: 8];
                    else if (7'(gi) == i_p)
                        w_byte = SHA256_PAD_BYTE;
                end
            end else begin : g_msg
                // Body bytes: message, then the marker, then zeros
                always_comb begin
                    w_byte = 8'h00;
                    if (i_extra) begin
                        if ((gi == 0) && (i_p == 7'(SHA256_BLOCK_BYTES)))
                            w_byte = SHA256_PAD_BYTE;
                    end else if (7'(gi) < i_p) begin
                        w_byte = i_buf[SHA256_BLOCK_BITS - 1 - 8 * gi -: 8];
                    end else if (7'(gi) == i_p) begin
                        w_byte = SHA256_PAD_BYTE;
                    end
                end
            end

            assign o_block[SHA256_BLOCK_BITS - 1 - 8 * gi -: 8] = w_byte;
        end
    endgenerate

endmodule

// File: rtl/sha256_msg_padder.sv
// Byte-stream to 512-bit block packer with SHA-256 message padding.
// The block presented to the core is formed combinationally from registered
// buffer/length/pointer state, so it is inherently stable while stalled.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int BLOCK_BYTES = SHA256_BLOCK_BYTES,
    parameter int LEN_BITS    = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [SHA256_BLOCK_BITS-1:0] blk_data,
    output logic                         blk_valid,
    output logic                         blk_last,
    input  logic                         blk_ready
);

    padder_state_t               r_state;
    logic [6:0]                  r_ptr;      // write pointer into the buffer
    logic [6:0]                  r_blk_p;    // byte count of the block in flight
    logic [LEN_BITS-1:0]         r_len;      // running message length in bits
    logic                        r_last;     // block in flight ends the message
    logic                        r_pending;  // a padding-only block must follow
    logic                        r_extra;    // block in flight is padding-only

    logic                        w_xfer;
    logic [6:0]                  w_p;
    logic [SHA256_BLOCK_BITS-1:0] w_buf_flat;
    logic [SHA256_BLOCK_BITS-1:0] w_block;
    logic [63:0]                 w_len_field;

    assign in_ready    = (r_state == FILL);
    assign w_xfer      = in_valid && in_ready;
    assign w_p         = r_ptr + 7'd1;
    assign w_len_field = 64'(r_len);

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_buf
            logic [7:0] r_byte;

            // Capture the incoming byte into the slot selected by the pointer
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_byte <= 8'h00;
                else if (w_xfer && (r_ptr == 7'(gi)))
                    r_byte <= in_data;
            end

            assign w_buf_flat[SHA256_BLOCK_BITS - 1 - 8 * gi -: 8] = r_byte;
        end
    endgenerate

    sha256_pad_builder u_builder (
        .i_buf   (w_buf_flat),
        .i_p     (r_blk_p),
        .i_len   (w_len_field),
        .i_extra (r_extra),
        .o_block (w_block)
    );

    // Padder FSM: collect bytes, present blocks, insert the padding-only block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_ptr     <= 7'd0;
            r_blk_p   <= 7'd0;
            r_len     <= '0;
            r_last    <= 1'b0;
            r_pending <= 1'b0;
            r_extra   <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_xfer) begin
                        r_len   <= r_len + LEN_BITS'(8);
                        r_ptr   <= w_p;
                        r_blk_p <= w_p;
                        if (in_last) begin
                            r_state <= SEND;
                            // Length only fits if the marker lands before byte 56
                            if (w_p <= 7'(SHA256_LEN_OFFSET - 1)) begin
                                r_last    <= 1'b1;
                                r_pending <= 1'b0;
                            end else begin
                                r_last    <= 1'b0;
                                r_pending <= 1'b1;
                            end
                        end else if (w_p == 7'(BLOCK_BYTES)) begin
                            r_state   <= SEND;
                            r_last    <= 1'b0;
                            r_pending <= 1'b0;
                        end
                    end
                end
                SEND: begin
                    if (blk_ready) begin
                        r_ptr  <= 7'd0;
                        r_last <= 1'b0;
                        if (r_last)
                            r_len <= '0;
                        if (r_pending) begin
                            r_state   <= EXTRA;
                            r_extra   <= 1'b1;
                            r_pending <= 1'b0;
                        end else begin
                            r_state <= FILL;
                            r_extra <= 1'b0;
                        end
                    end
                end
                EXTRA: begin
                    r_state <= SEND;
                    r_last  <= 1'b1;
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign blk_valid = (r_state == SEND);
    assign blk_last  = r_last;
    assign blk_data  = blk_valid ? w_block : '0;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for the SHA-256 message padder.
module tb_sha256_msg_padder;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]   msg   [0:255];
    logic [7:0]   exp_b [0:255];
    int           exp_nblk;
    logic [511:0] got   [0:3];

    sha256_msg_padder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_ready (blk_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference padding: message, 0x80, zeros, 64-bit big-endian bit length
    task automatic build_expected(input int n);
        int total;
        logic [63:0] bits;
        total = ((n + 8) / 64 + 1) * 64;
        for (int k = 0; k < 256; k++) exp_b[k] = 8'h00;
        for (int k = 0; k < n; k++) exp_b[k] = msg[k];
        exp_b[n] = 8'h80;
        bits = 64'(n) * 64'd8;
        for (int j = 0; j < 8; j++) exp_b[total - 8 + j] = bits[(7 - j) * 8 +: 8];
        exp_nblk = total / 64;
    endtask

    task automatic run_msg(input int n, input int stall);
        int i, blk, scnt, budget, gap;
        logic sent_last;
        logic [511:0] held, expv;
        build_expected(n);
        i = 0; blk = 0; scnt = 0; budget = 0; gap = 0; sent_last = 1'b0;
        held = '0;
        while (blk < exp_nblk) begin
            @(posedge clk); #1;
            budget++;
            if (budget > 3000) begin
                checks++; errors++;
                $display("FAIL timeout n=%0d blocks got %0d required %0d", n, blk, exp_nblk);
                break;
            end
            if (sent_last) begin
                checks++;
                if (blk_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency n=%0d blk_valid got %b required 1", n, blk_valid);
                end
                sent_last = 1'b0;
            end
            if (blk_valid === 1'b1) begin
                in_valid = 1'b0; in_last = 1'b0;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_in_send n=%0d got %b required 0", n, in_ready);
                end
                if (scnt == 0) begin
                    for (int k = 0; k < 64; k++) expv[511 - 8 * k -: 8] = exp_b[blk * 64 + k];
                    checks++;
                    if (blk_data !== expv) begin
                        errors++;
                        $display("FAIL blk_data n=%0d blk %0d got %h required %h", n, blk, blk_data, expv);
                    end
                    checks++;
                    if (blk_last !== (blk == exp_nblk - 1)) begin
                        errors++;
                        $display("FAIL blk_last n=%0d blk %0d got %b required %b", n, blk, blk_last, (blk == exp_nblk - 1));
                    end
                    if (i == n && blk > 0) begin
                        checks++;
                        if (gap > 1) begin
                            errors++;
                            $display("FAIL extra_gap n=%0d got %0d idle cycles required <=1", n, gap);
                        end
                    end
                    held = blk_data;
                    if (blk < 4) got[blk] = blk_data;
                    $display("block n=%0d idx=%0d last=%b len_field=%h", n, blk, blk_last, blk_data[63:0]);
                end else begin
                    checks++;
                    if (blk_data !== held) begin
                        errors++;
                        $display("FAIL stall_stable n=%0d blk %0d got %h required %h", n, blk, blk_data, held);
                    end
                end
                gap = 0;
                if (scnt == stall) begin
                    blk_ready = 1'b1; blk++; scnt = 0;
                end else begin
                    blk_ready = 1'b0; scnt++;
                end
            end else begin
                blk_ready = 1'b1;  // must have no effect while no block is offered
                if (i == n) begin
                    gap++;
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL in_ready_extra n=%0d got %b required 0", n, in_ready);
                    end
                    in_valid = 1'b0; in_last = 1'b1; in_data = 8'hA5;
                end else begin
                    checks++;
                    if (in_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL in_ready_fill n=%0d got %b required 1", n, in_ready);
                    end else begin
                        in_valid = 1'b1; in_data = msg[i]; in_last = (i == n - 1);
                        if (i == n - 1) sent_last = 1'b1;
                        i++;
                    end
                end
            end
        end
        @(posedge clk); #1;
        blk_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after n=%0d valid/ready got %b%b required 01", n, blk_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_last !== 1'b0 || blk_data !== '0) begin
            errors++;
            $display("FAIL reset got ready=%b valid=%b last=%b data_nz=%b required 1 0 0 0", in_ready, blk_valid, blk_last, |blk_data);
        end
        $display("reset checked");
    endtask

    task automatic check_abc();
        logic [511:0] req;
        req = {32'h61626380, 416'h0, 64'h18};
        checks++;
        if (got[0] !== req) begin
            errors++;
            $display("FAIL abc_const got %h required %h", got[0], req);
        end
    endtask

    task automatic test_abc();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_msg(3, 0);
        check_abc();
    endtask

    task automatic test_55_zero();
        for (int k = 0; k < 55; k++) msg[k] = 8'h00;
        run_msg(55, 0);
        checks++;
        if (got[0][71:64] !== 8'h80 || got[0][63:0] !== 64'h1B8) begin
            errors++;
            $display("FAIL pad55 got marker %h len %h required 80 1b8", got[0][71:64], got[0][63:0]);
        end
    endtask

    task automatic test_56_bytes();
        for (int k = 0; k < 56; k++) msg[k] = 8'h41;
        run_msg(56, 0);
        checks++;
        if (got[0] !== {{56{8'h41}}, 8'h80, 56'h0}) begin
            errors++;
            $display("FAIL pad56_blk0 got %h", got[0]);
        end
        checks++;
        if (got[1] !== {448'h0, 64'h1C0}) begin
            errors++;
            $display("FAIL pad56_blk1 got %h required len 1c0", got[1]);
        end
    endtask

    task automatic test_64_bytes();
        for (int k = 0; k < 64; k++) msg[k] = 8'hFF;
        run_msg(64, 0);
        checks++;
        if (got[0] !== {64{8'hFF}}) begin
            errors++;
            $display("FAIL pad64_blk0 got %h required all ff", got[0]);
        end
        checks++;
        if (got[1] !== {8'h80, 440'h0, 64'h200}) begin
            errors++;
            $display("FAIL pad64_blk1 got %h required 80..0200", got[1]);
        end
    endtask

    task automatic test_stall_130();
        for (int k = 0; k < 130; k++) msg[k] = 8'(k * 7 + 3);
        run_msg(130, 5);
        checks++;
        if (exp_nblk != 3 || got[2][63:0] !== 64'h410) begin
            errors++;
            $display("FAIL stall130 len got %h required 410", got[2][63:0]);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = 8'(k + 1); in_last = 1'b0;
            checks++;
            if (blk_valid !== 1'b0) begin
                errors++;
                $display("FAIL early_block byte %0d blk_valid got %b required 0", k, blk_valid);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (blk_valid !== 1'b0 || blk_data !== '0) begin
            errors++;
            $display("FAIL mid_reset valid got %b required 0", blk_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        got[0] = '0;
        test_abc();
        $display("mid-reset then abc done");
    endtask

    initial begin
        test_reset();
        test_abc();
        test_55_zero();
        test_56_bytes();
        test_64_bytes();
        test_stall_130();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
